// File: rtl/multichannel_pid_controller.sv
// Time-multiplexed PID controller: one shared datapath evaluates NUM_CHANNELS
// channels per sweep (latch, then ERR/TERMS/SUM/SAT for each channel).
module multichannel_pid_controller #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ACC_WIDTH    = 64,
  parameter int unsigned CH_W         = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               cfg_write,
  input  logic [CH_W-1:0]                    cfg_channel,
  input  logic [3:0]                         cfg_addr,
  input  logic [DATA_WIDTH-1:0]              cfg_data,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] position,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] velocity,
  input  logic                               update_controller,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] duty,
  output logic                               busy,
  output logic                               done
);
  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned AW = ACC_WIDTH;
  localparam logic [CH_W-1:0] LastCh = CH_W'(NUM_CHANNELS - 1);

  typedef enum logic [2:0] {StIdle, StLatch, StErr, StTerms, StSum, StSat} state_e;

  function automatic logic signed [DW:0] ext1(input logic signed [DW-1:0] v);
    return $signed({v[DW-1], v});
  endfunction

  function automatic logic signed [AW-1:0] sx(input logic signed [DW-1:0] v);
    return $signed({{(AW-DW){v[DW-1]}}, v});
  endfunction

  // Per-channel register file
  logic signed [DW-1:0] kp_q [NUM_CHANNELS];
  logic signed [DW-1:0] ki_q [NUM_CHANNELS];
  logic signed [DW-1:0] kd_q [NUM_CHANNELS];
  logic signed [DW-1:0] sp_q [NUM_CHANNELS];
  logic signed [DW-1:0] pos_max_q [NUM_CHANNELS];
  logic signed [DW-1:0] neg_max_q [NUM_CHANNELS];
  logic signed [DW-1:0] dead_band_q [NUM_CHANNELS];
  logic signed [DW-1:0] zero_speed_q [NUM_CHANNELS];
  logic signed [DW-1:0] int_max_q [NUM_CHANNELS];
  logic [4:0]           shift_q [NUM_CHANNELS];
  logic [1:0]           mode_q [NUM_CHANNELS];
  logic signed [DW-1:0] integral_q [NUM_CHANNELS];
  logic signed [DW-1:0] last_err_q [NUM_CHANNELS];
  logic signed [DW-1:0] pos_snap_q [NUM_CHANNELS];
  logic signed [DW-1:0] vel_snap_q [NUM_CHANNELS];
  logic signed [DW-1:0] duty_q [NUM_CHANNELS];

  state_e          state_q;
  logic [CH_W-1:0] ch_q;
  logic            update_prev_q, pending_q;

  // Values captured at ERR and carried down the per-channel pipeline
  logic signed [DW-1:0] err_q, int_q, kp_w, ki_w, kd_w, sp_w, zs_w, pos_w, neg_w;
  logic signed [DW:0]   derr_q;
  logic [4:0]           shift_w;
  logic                 in_db_q, direct_q;
  logic signed [AW-1:0] p_q, i_q, d_q, s_q;

  logic start, cfg_hit, mode_clr;
  assign start    = update_controller && !update_prev_q;
  assign cfg_hit  = cfg_write && (32'(cfg_channel) < NUM_CHANNELS);
  assign mode_clr = cfg_hit && (cfg_addr == 4'd10);

  // Config port writes
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        kp_q[i] <= '0; ki_q[i] <= '0; kd_q[i] <= '0; sp_q[i] <= '0;
        pos_max_q[i] <= '0; neg_max_q[i] <= '0; dead_band_q[i] <= '0;
        zero_speed_q[i] <= '0; int_max_q[i] <= '0; shift_q[i] <= '0; mode_q[i] <= '0;
      end
    end else if (cfg_hit) begin
      case (cfg_addr)
        4'd0:    kp_q[cfg_channel]         <= cfg_data;
        4'd1:    ki_q[cfg_channel]         <= cfg_data;
        4'd2:    kd_q[cfg_channel]         <= cfg_data;
        4'd3:    sp_q[cfg_channel]         <= cfg_data;
        4'd4:    pos_max_q[cfg_channel]    <= cfg_data;
        4'd5:    neg_max_q[cfg_channel]    <= cfg_data;
        4'd6:    dead_band_q[cfg_channel]  <= cfg_data;
        4'd7:    zero_speed_q[cfg_channel] <= cfg_data;
        4'd8:    shift_q[cfg_channel]      <= cfg_data[4:0];
        4'd9:    int_max_q[cfg_channel]    <= cfg_data;
        4'd10:   mode_q[cfg_channel]       <= cfg_data[1:0];
        default: ;
      endcase
    end
  end

  logic signed [DW-1:0] meas_c, err_c, int_next_c;
  logic signed [DW:0]   err_wide, int_sum, imax_e, db_e, derr_c;
  logic                 in_db_c;

  // ERR stage: saturated error, deadband test, clamped integrator, error delta
  always_comb begin
    meas_c   = (mode_q[ch_q] == 2'd1) ? vel_snap_q[ch_q] : pos_snap_q[ch_q];
    err_wide = ext1(sp_q[ch_q]) - ext1(meas_c);
    if (mode_q[ch_q] == 2'd3) begin
      err_c = '0;
    end else if (err_wide[DW] != err_wide[DW-1]) begin
      err_c = err_wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
    end else begin
      err_c = err_wide[DW-1:0];
    end
    db_e    = ext1(dead_band_q[ch_q]);
    in_db_c = (-db_e < ext1(err_c)) && (ext1(err_c) < db_e);
    int_sum = ext1(integral_q[ch_q]) + ext1(err_c);
    imax_e  = ext1(int_max_q[ch_q]);
    if (in_db_c) begin
      int_next_c = integral_q[ch_q];
    end else if (int_sum > imax_e) begin
      int_next_c = int_max_q[ch_q];
    end else if (int_sum < -imax_e) begin
      int_next_c = -int_max_q[ch_q];
    end else begin
      int_next_c = int_sum[DW-1:0];
    end
    derr_c = ext1(err_c) - ext1(last_err_q[ch_q]);
  end

  logic signed [AW-1:0] r_c;
  logic signed [DW-1:0] duty_c;

  // SAT stage: offset from zero_speed, clamp with NegMax taking precedence
  always_comb begin
    r_c = sx(zs_w) - s_q;
    if (r_c < sx(neg_w)) begin
      r_c = sx(neg_w);
    end else if (r_c > sx(pos_w)) begin
      r_c = sx(pos_w);
    end
    if (direct_q) begin
      duty_c = sp_w;
    end else if (in_db_q) begin
      duty_c = zs_w;
    end else begin
      duty_c = r_c[DW-1:0];
    end
  end

  // Sweep sequencer, datapath pipeline and per-channel controller state
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= StIdle; ch_q <= '0; update_prev_q <= 1'b0; pending_q <= 1'b0;
      busy <= 1'b0; done <= 1'b0;
      err_q <= '0; int_q <= '0; derr_q <= '0; in_db_q <= 1'b0; direct_q <= 1'b0;
      kp_w <= '0; ki_w <= '0; kd_w <= '0; sp_w <= '0; zs_w <= '0;
      pos_w <= '0; neg_w <= '0; shift_w <= '0;
      p_q <= '0; i_q <= '0; d_q <= '0; s_q <= '0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        integral_q[i] <= '0; last_err_q[i] <= '0; duty_q[i] <= '0;
        pos_snap_q[i] <= '0; vel_snap_q[i] <= '0;
      end
    end else begin
      update_prev_q <= update_controller;
      done          <= 1'b0;
      if (start && (state_q != StIdle)) pending_q <= 1'b1;
      case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StLatch;
            busy    <= 1'b1;
          end
        end
        StLatch: begin
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            pos_snap_q[i] <= position[i*DW +: DW];
            vel_snap_q[i] <= velocity[i*DW +: DW];
          end
          ch_q    <= '0;
          state_q <= StErr;
        end
        StErr: begin
          err_q    <= err_c;
          int_q    <= int_next_c;
          derr_q   <= derr_c;
          in_db_q  <= in_db_c;
          direct_q <= (mode_q[ch_q] == 2'd2);
          kp_w <= kp_q[ch_q]; ki_w <= ki_q[ch_q]; kd_w <= kd_q[ch_q];
          sp_w <= sp_q[ch_q]; zs_w <= zero_speed_q[ch_q];
          pos_w <= pos_max_q[ch_q]; neg_w <= neg_max_q[ch_q]; shift_w <= shift_q[ch_q];
          if (mode_q[ch_q] == 2'd2) begin
            integral_q[ch_q] <= '0;
            last_err_q[ch_q] <= '0;
          end else begin
            integral_q[ch_q] <= int_next_c;
            last_err_q[ch_q] <= err_c;
          end
          state_q <= StTerms;
        end
        StTerms: begin
          p_q <= sx(err_q) * sx(kp_w);
          i_q <= sx(int_q) * sx(ki_w);
          d_q <= $signed({{(AW-DW-1){derr_q[DW]}}, derr_q}) * sx(kd_w);
          state_q <= StSum;
        end
        StSum: begin
          s_q     <= (p_q + i_q + d_q) >>> shift_w;
          state_q <= StSat;
        end
        StSat: begin
          duty_q[ch_q] <= duty_c;
          if (ch_q == LastCh) begin
            done <= 1'b1;
            // A start seen during the sweep chains straight into a new one
            if (pending_q || start) begin
              pending_q <= 1'b0;
              state_q   <= StLatch;
            end else begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end
          end else begin
            ch_q    <= ch_q + 1'b1;
            state_q <= StErr;
          end
        end
        default: state_q <= StIdle;
      endcase
      // Changing a channel's mode restarts its controller state
      if (mode_clr) begin
        integral_q[cfg_channel] <= '0;
        last_err_q[cfg_channel] <= '0;
      end
    end
  end

  // Pack per-channel duty words onto the output bus
  always_comb begin
    duty = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) duty[i*DW +: DW] = duty_q[i];
  end

endmodule

// File: tb/tb_multichannel_pid_controller.sv
// Directed bench for multichannel_pid_controller (4 channels, 32/64-bit).
module tb_multichannel_pid_controller;
  localparam int N  = 4;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset;
  logic            cfg_write;
  logic [1:0]      cfg_channel;
  logic [3:0]      cfg_addr;
  logic [DW-1:0]   cfg_data;
  logic [N*DW-1:0] position, velocity, duty;
  logic            update_controller, busy, done;

  int checks = 0;
  int errors = 0;

  multichannel_pid_controller #(
    .NUM_CHANNELS(N), .DATA_WIDTH(DW), .ACC_WIDTH(64)
  ) dut (
    .clock(clock), .reset(reset), .cfg_write(cfg_write), .cfg_channel(cfg_channel),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .position(position), .velocity(velocity),
    .update_controller(update_controller), .duty(duty), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [DW-1:0] duty_of(input int k);
    return duty[k*DW +: DW];
  endfunction

  task automatic cfg_wr(input int ch, input int addr, input int data);
    cfg_write   = 1'b1;
    cfg_channel = 2'(ch);
    cfg_addr    = 4'(addr);
    cfg_data    = data;
    @(negedge clock);
    cfg_write = 1'b0;
  endtask

  // One sweep: pulse update, wait (bounded) for done, then settle one cycle
  task automatic sweep(input string tag);
    bit seen = 1'b0;
    update_controller = 1'b1;
    @(negedge clock);
    update_controller = 1'b0;
    for (int j = 1; j <= 40; j++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check(tag, seen, 1);
    @(negedge clock);
  endtask

  int exp3[5] = '{-100, -200, -250, -250, -250};
  int n_done, first_done, second_done;

  initial begin
    reset = 1'b0; cfg_write = 1'b0; cfg_channel = '0; cfg_addr = '0; cfg_data = '0;
    position = '0; velocity = '0; update_controller = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_duty", duty, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset = 1'b1;
    @(negedge clock);

    // Test 1: proportional only, exact timing
    cfg_wr(0, 0, 2); cfg_wr(0, 4, 1000); cfg_wr(0, 5, -1000); cfg_wr(0, 3, 100);
    position[31:0] = 40;
    update_controller = 1'b1;
    @(negedge clock);
    update_controller = 1'b0;
    check("t1_busy_e1", busy, 1);
    repeat (4) @(negedge clock);
    check("t1_duty0_e5", duty_of(0), 0);
    @(negedge clock);
    check("t1_duty0_e6", duty_of(0), -120);
    repeat (11) @(negedge clock);
    check("t1_busy_e17", busy, 1);
    check("t1_done_e17", done, 0);
    @(negedge clock);
    check("t1_done_e18", done, 1);
    check("t1_busy_e18", busy, 0);
    @(negedge clock);
    check("t1_done_e19", done, 0);

    // Test 2: output saturation both ways
    cfg_wr(0, 4, 50); cfg_wr(0, 5, -50);
    sweep("t2a_done");
    check("t2_negsat", duty_of(0), -50);
    cfg_wr(0, 3, -100);
    sweep("t2b_done");
    check("t2_possat", duty_of(0), 50);

    // Test 3: integral with anti-windup clamp
    cfg_wr(1, 1, 1); cfg_wr(1, 9, 250); cfg_wr(1, 4, 1000); cfg_wr(1, 5, -1000);
    cfg_wr(1, 3, 100);
    for (int s = 0; s < 5; s++) begin
      sweep("t3_done");
      check($sformatf("t3_duty1_s%0d", s), duty_of(1), exp3[s]);
    end
    cfg_wr(1, 10, 0);
    sweep("t3c_done");
    check("t3_modeclr", duty_of(1), -100);

    // Test 4: deadband then derivative
    cfg_wr(2, 2, 3); cfg_wr(2, 6, 20); cfg_wr(2, 7, 7); cfg_wr(2, 4, 1000);
    cfg_wr(2, 5, -1000); cfg_wr(2, 3, 10);
    sweep("t4a_done");
    check("t4_deadband", duty_of(2), 7);
    cfg_wr(2, 7, 0); cfg_wr(2, 3, 30);
    sweep("t4b_done");
    check("t4_dterm", duty_of(2), -60);

    // Test 5: direct mode plus coalesced starts while busy
    cfg_wr(3, 10, 2); cfg_wr(3, 3, 777);
    n_done = 0; first_done = -1; second_done = -1;
    for (int j = 0; j < 60; j++) begin
      if (j > 0 && done) begin
        n_done++;
        if (first_done < 0) first_done = j;
        else if (second_done < 0) second_done = j;
      end
      update_controller = (j == 0 || j == 3 || j == 7);
      @(negedge clock);
    end
    check("t5_ndone", n_done, 2);
    check("t5_first_done", first_done, 18);
    check("t5_second_done", second_done, 35);
    check("t5_busy_end", busy, 0);
    check("t5_direct", duty_of(3), 777);

    // Test 6: reset in the middle of channel 1
    update_controller = 1'b1;
    @(negedge clock);
    update_controller = 1'b0;
    repeat (6) @(negedge clock);
    check("t6_busy_pre", busy, 1);
    check("t6_duty0_pre", duty_of(0), 50);
    reset = 1'b0;
    @(negedge clock);
    check("t6_duty_rst", duty, 0);
    check("t6_busy_rst", busy, 0);
    check("t6_done_rst", done, 0);
    reset = 1'b1;
    n_done = 0;
    repeat (30) begin
      if (done) n_done++;
      @(negedge clock);
    end
    check("t6_no_done", n_done, 0);
    sweep("t6_post_done");
    check("t6_cfg_cleared", duty_of(3), 0);
    check("t6_duty0_post", duty_of(0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute guard so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule
